// File: rtl/activity_tracker.sv
// Step-activity core: counts steps, distance, early fast seconds and sustained
// high-activity time, and rotates a display selector across the four stats.
module activity_tracker #(
    parameter int unsigned TICKS_PER_SEC   = 100_000_000,
    parameter int unsigned STEP_MAX        = 9999,
    parameter int unsigned HALF_MILE_STEPS = 1024,
    parameter int unsigned FAST_THRESH     = 32,
    parameter int unsigned EARLY_SECS      = 9,
    parameter int unsigned HIGH_THRESH     = 64,
    parameter int unsigned HIGH_MIN_SECS   = 60,
    parameter int unsigned DISP_SECS       = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        step,
    output logic [15:0] step_count,
    output logic        si,
    output logic [15:0] distance,
    output logic [3:0]  fast_secs,
    output logic [15:0] high_time,
    output logic        sec_tick,
    output logic [1:0]  disp_sel,
    output logic [15:0] disp_value
);

    localparam int TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int HW = (HALF_MILE_STEPS > 1) ? $clog2(HALF_MILE_STEPS) : 1;
    localparam int RW = $clog2(HIGH_MIN_SECS + 1);
    localparam int DW = (DISP_SECS > 1) ? $clog2(DISP_SECS) : 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_SEC - 1);
    localparam logic [TW-1:0] TICK_ONE  = TW'(1);
    localparam logic [HW-1:0] HALF_LAST = HW'(HALF_MILE_STEPS - 1);
    localparam logic [HW-1:0] HALF_ONE  = HW'(1);
    localparam logic [RW-1:0] RUN_FULL  = RW'(HIGH_MIN_SECS);
    localparam logic [RW-1:0] RUN_ONE   = RW'(1);
    localparam logic [DW-1:0] DISP_LAST = DW'(DISP_SECS - 1);
    localparam logic [DW-1:0] DISP_ONE  = DW'(1);
    localparam logic [15:0]   STEP_SAT  = 16'(STEP_MAX);

    logic          r_start_d;
    logic [TW-1:0] r_tick;
    logic [7:0]    r_sec_steps;
    logic [HW-1:0] r_half;
    logic [3:0]    r_elapsed;
    logic [RW-1:0] r_run;
    logic [DW-1:0] r_disp_cnt;
    logic [1:0]    r_sel;
    logic [15:0]   r_steps;
    logic          r_si;
    logic [15:0]   r_dist;
    logic [3:0]    r_fast;
    logic [15:0]   r_high;

    logic          w_clr;
    logic          w_run;
    logic          w_step;
    logic          w_tick;
    logic [7:0]    w_eval;
    logic          w_fast;
    logic          w_high;
    logic [16:0]   w_high_sum;

    // A start edge is a clearing cycle, not a tracking cycle: steps and ticks are ignored.
    assign w_clr  = start & ~r_start_d;
    assign w_run  = start & r_start_d;
    assign w_step = w_run & step;
    assign w_tick = w_run & (r_tick == TICK_LAST);

    // The closing second includes a step that lands on its own tick cycle.
    assign w_eval     = (w_step && r_sec_steps != 8'hFF) ? r_sec_steps + 8'd1 : r_sec_steps;
    assign w_fast     = 32'(w_eval) > FAST_THRESH;
    assign w_high     = 32'(w_eval) >= HIGH_THRESH;
    assign w_high_sum = {1'b0, r_high} + 17'(HIGH_MIN_SECS);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_start_d <= 1'b0;
            r_tick    <= '0;
        end else begin
            r_start_d <= start;
            if (w_clr)
                r_tick <= '0;
            else if (w_run)
                r_tick <= w_tick ? '0 : r_tick + TICK_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sec_steps <= '0;
        end else if (w_clr || w_tick) begin
            r_sec_steps <= '0;
        end else if (w_step && r_sec_steps != 8'hFF) begin
            r_sec_steps <= r_sec_steps + 8'd1;
        end
    end

    // The half-mile sub-counter keeps running after step_count saturates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_steps <= '0;
            r_si    <= 1'b0;
            r_half  <= '0;
            r_dist  <= '0;
        end else if (w_clr) begin
            r_steps <= '0;
            r_si    <= 1'b0;
            r_half  <= '0;
            r_dist  <= '0;
        end else if (w_step) begin
            if (r_steps == STEP_SAT)
                r_si <= 1'b1;
            else
                r_steps <= r_steps + 16'd1;
            if (r_half == HALF_LAST) begin
                r_half <= '0;
                if (r_dist != 16'hFFFF)
                    r_dist <= r_dist + 16'd1;
            end else begin
                r_half <= r_half + HALF_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_elapsed <= '0;
            r_fast    <= '0;
            r_run     <= '0;
            r_high    <= '0;
        end else if (w_clr) begin
            r_elapsed <= '0;
            r_fast    <= '0;
            r_run     <= '0;
            r_high    <= '0;
        end else if (w_tick) begin
            if (r_elapsed != 4'hF)
                r_elapsed <= r_elapsed + 4'd1;
            if (32'(r_elapsed) < EARLY_SECS && w_fast && r_fast != 4'hF)
                r_fast <= r_fast + 4'd1;
            // The whole qualifying run is credited at once when it first reaches full length.
            if (!w_high) begin
                r_run <= '0;
            end else if (r_run == RUN_FULL - RUN_ONE) begin
                r_run  <= RUN_FULL;
                r_high <= w_high_sum[16] ? 16'hFFFF : w_high_sum[15:0];
            end else if (r_run == RUN_FULL) begin
                if (r_high != 16'hFFFF)
                    r_high <= r_high + 16'd1;
            end else begin
                r_run <= r_run + RUN_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_disp_cnt <= '0;
            r_sel      <= '0;
        end else if (w_tick) begin
            if (r_disp_cnt == DISP_LAST) begin
                r_disp_cnt <= '0;
                r_sel      <= r_sel + 2'd1;
            end else begin
                r_disp_cnt <= r_disp_cnt + DISP_ONE;
            end
        end
    end

    always_comb begin
        disp_value = r_steps;
        case (r_sel)
            2'd0: disp_value = r_steps;
            2'd1: disp_value = r_dist;
            2'd2: disp_value = {12'd0, r_fast};
            2'd3: disp_value = r_high;
            default: disp_value = r_steps;
        endcase
    end

    assign step_count = r_steps;
    assign si         = r_si;
    assign distance   = r_dist;
    assign fast_secs  = r_fast;
    assign high_time  = r_high;
    assign sec_tick   = w_tick;
    assign disp_sel   = r_sel;

endmodule
